// File: rtl/piso_tx4.sv
`default_nettype none
// ============================================================================
//  Module      : piso_tx4
//  Description : 4-bit parallel-in / serial-out transmitter with a
//                valid/ready load handshake. Frames are sent on consecutive
//                cycles, and the next frame can start with no idle gap.
//                Optional even-parity fifth bit, enabled by defining the
//                macro PIPO_TX_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_tx4 #(
  parameter int MSB_FIRST = 1
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [3:0] D,
  input  logic       load_valid,
  output logic       load_ready,
  output logic       sout,
  output logic       sout_valid,
  output logic       frame_start,
  output logic       busy
);

`ifdef PIPO_TX_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  shreg_q, shreg_d;
  logic        sout_q, sout_d;
  logic        sout_valid_q, sout_valid_d;
  logic        frame_start_q, frame_start_d;
  logic        busy_q, busy_d;
`ifdef PIPO_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  logic        w_final_bit;
  logic        w_accept;
  logic        w_first_bit;
  logic        w_next_bit;
  logic [3:0]  w_shifted;

  // The last serial bit of a frame is the only cycle besides IDLE where a new
  // word may be taken, which is what makes back-to-back frames gapless.
`ifdef PIPO_TX_PARITY_EN
  assign w_final_bit = (state_q == PARITY);
`else
  assign w_final_bit = (state_q == SHIFT) && (cnt_q == 2'd3);
`endif

  // Ready is forced low while reset is held, and rises as soon as it drops.
  assign load_ready = !reset && ((state_q == IDLE) || w_final_bit);
  assign w_accept   = load_valid && load_ready;

  // The register holds the captured word; sout shows the bit at the head of
  // the register, so the bit for the next cycle is the one behind the head.
  assign w_first_bit = (MSB_FIRST != 0) ? D[3] : D[0];
  assign w_next_bit  = (MSB_FIRST != 0) ? shreg_q[2] : shreg_q[1];
  assign w_shifted   = (MSB_FIRST != 0) ? {shreg_q[2:0], 1'b0}
                                        : {1'b0, shreg_q[3:1]};

  // Next-state and next-output decode; outputs default to the idle values.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shreg_d       = shreg_q;
    sout_d        = 1'b0;
    sout_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    busy_d        = 1'b0;
`ifdef PIPO_TX_PARITY_EN
    parity_d      = parity_q;
`endif

    if (w_accept) begin
      state_d       = SHIFT;
      cnt_d         = 2'd0;
      shreg_d       = D;
      sout_d        = w_first_bit;
      sout_valid_d  = 1'b1;
      frame_start_d = 1'b1;
      busy_d        = 1'b1;
`ifdef PIPO_TX_PARITY_EN
      parity_d      = ^D;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        SHIFT: begin
          if (cnt_q != 2'd3) begin
            cnt_d        = cnt_q + 2'd1;
            shreg_d      = w_shifted;
            sout_d       = w_next_bit;
            sout_valid_d = 1'b1;
            busy_d       = 1'b1;
          end else begin
`ifdef PIPO_TX_PARITY_EN
            state_d      = PARITY;
            sout_d       = parity_q;
            sout_valid_d = 1'b1;
            busy_d       = 1'b1;
`else
            state_d      = IDLE;
`endif
          end
        end
`ifdef PIPO_TX_PARITY_EN
        PARITY: begin
          state_d = IDLE;
        end
`endif
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and registered outputs; reset aborts any frame immediately.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 2'd0;
      shreg_q       <= 4'd0;
      sout_q        <= 1'b0;
      sout_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
`ifdef PIPO_TX_PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shreg_q       <= shreg_d;
      sout_q        <= sout_d;
      sout_valid_q  <= sout_valid_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
`ifdef PIPO_TX_PARITY_EN
      parity_q      <= parity_d;
`endif
    end
  end

  assign sout        = sout_q;
  assign sout_valid  = sout_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_piso_tx4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_tx4
//  Description : Directed self-checking bench for piso_tx4 (MSB-first and
//                LSB-first instances). Honours PIPO_TX_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_tx4;

`ifdef PIPO_TX_PARITY_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif

  logic       CLK = 1'b0;
  logic       reset;
  logic [3:0] D;
  logic       load_valid;

  logic lr_m, so_m, sv_m, fs_m, bz_m;
  logic lr_l, so_l, sv_l, fs_l, bz_l;

  int total = 0;
  int bad   = 0;

  piso_tx4 #(.MSB_FIRST(1)) dut_m (
    .CLK(CLK), .reset(reset), .D(D), .load_valid(load_valid),
    .load_ready(lr_m), .sout(so_m), .sout_valid(sv_m),
    .frame_start(fs_m), .busy(bz_m)
  );

  piso_tx4 #(.MSB_FIRST(0)) dut_l (
    .CLK(CLK), .reset(reset), .D(D), .load_valid(load_valid),
    .load_ready(lr_l), .sout(so_l), .sout_valid(sv_l),
    .frame_start(fs_l), .busy(bz_l)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Idle outputs of the MSB-first instance.
  task automatic chk_idle(input string tag);
    chk({tag, ".sout"},  {31'd0, so_m}, 32'd0);
    chk({tag, ".valid"}, {31'd0, sv_m}, 32'd0);
    chk({tag, ".fs"},    {31'd0, fs_m}, 32'd0);
    chk({tag, ".busy"},  {31'd0, bz_m}, 32'd0);
    chk({tag, ".ready"}, {31'd0, lr_m}, 32'd1);
  endtask

  // Walks n frame-bit cycles; seq is written left-to-right in send order.
  // lv_pat[i] / chg_at set the inputs seen by the edge closing cycle i.
  task automatic chk_seq(input string tag, input logic [15:0] seq, input int n,
                         input logic [15:0] lv_pat, input int chg_at,
                         input logic [3:0] chg_d, input bit use_l);
    logic s, v, f, b, r;
    for (int i = 0; i < n; i++) begin
      s = use_l ? so_l : so_m;
      v = use_l ? sv_l : sv_m;
      f = use_l ? fs_l : fs_m;
      b = use_l ? bz_l : bz_m;
      r = use_l ? lr_l : lr_m;
      chk($sformatf("%s.sout[%0d]", tag, i),  {31'd0, s}, {31'd0, seq[n-1-i]});
      chk($sformatf("%s.valid[%0d]", tag, i), {31'd0, v}, 32'd1);
      chk($sformatf("%s.fs[%0d]", tag, i),    {31'd0, f}, {31'd0, (i % FL) == 0});
      chk($sformatf("%s.busy[%0d]", tag, i),  {31'd0, b}, 32'd1);
      chk($sformatf("%s.ready[%0d]", tag, i), {31'd0, r}, {31'd0, (i % FL) == FL-1});
      load_valid = lv_pat[i];
      if (i == chg_at) D = chg_d;
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    D = 4'd0;
    load_valid = 1'b0;
    #2;
    chk("rst.sout",  {31'd0, so_m}, 32'd0);
    chk("rst.valid", {31'd0, sv_m}, 32'd0);
    chk("rst.fs",    {31'd0, fs_m}, 32'd0);
    chk("rst.busy",  {31'd0, bz_m}, 32'd0);
    chk("rst.ready", {31'd0, lr_m}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Idle hold for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("hold.valid[%0d]", i), {31'd0, sv_m}, 32'd0);
      chk($sformatf("hold.busy[%0d]", i),  {31'd0, bz_m}, 32'd0);
      chk($sformatf("hold.ready[%0d]", i), {31'd0, lr_m}, 32'd1);
      tick();
    end

    // Single frame, MSB first, D=0011.
    D = 4'b0011; load_valid = 1'b1;
    tick();
`ifdef PIPO_TX_PARITY_EN
    chk_seq("single", 16'b00110, FL, 16'd0, -1, 4'd0, 1'b0);
`else
    chk_seq("single", 16'b0011, FL, 16'd0, -1, 4'd0, 1'b0);
`endif
    chk_idle("single.end");

    // Bit order, LSB first, D=1100.
    D = 4'b1100; load_valid = 1'b1;
    tick();
`ifdef PIPO_TX_PARITY_EN
    chk_seq("lsb", 16'b00110, FL, 16'd0, -1, 4'd0, 1'b1);
`else
    chk_seq("lsb", 16'b0011, FL, 16'd0, -1, 4'd0, 1'b1);
`endif
    chk("lsb.end.valid", {31'd0, sv_l}, 32'd0);
    chk("lsb.end.ready", {31'd0, lr_l}, 32'd1);

    // Back-to-back: 0101 then 1101 offered in the final bit cycle.
    D = 4'b0101; load_valid = 1'b1;
    tick();
`ifdef PIPO_TX_PARITY_EN
    chk_seq("b2b", 16'b0101011011, 2*FL, 16'b0000011111, FL-1, 4'b1101, 1'b0);
`else
    chk_seq("b2b", 16'b01011101, 2*FL, 16'b00001111, FL-1, 4'b1101, 1'b0);
`endif
    chk_idle("b2b.end");

    // Ignore while busy: 1111 offered only during the counter=1 cycle.
    D = 4'b0100; load_valid = 1'b1;
    tick();
`ifdef PIPO_TX_PARITY_EN
    chk_seq("ign", 16'b01001, FL, 16'b00010, 1, 4'b1111, 1'b0);
`else
    chk_seq("ign", 16'b0100, FL, 16'b0010, 1, 4'b1111, 1'b0);
`endif
    chk_idle("ign.end");
    tick();
    chk_idle("ign.end2");

    // Reset mid-frame, 2 ns after the counter=1 edge.
    D = 4'b1111; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    chk("mid.pre.valid", {31'd0, sv_m}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("mid.sout",  {31'd0, so_m}, 32'd0);
    chk("mid.valid", {31'd0, sv_m}, 32'd0);
    chk("mid.fs",    {31'd0, fs_m}, 32'd0);
    chk("mid.busy",  {31'd0, bz_m}, 32'd0);
    chk("mid.ready", {31'd0, lr_m}, 32'd0);
    tick();
    chk("mid.held.valid", {31'd0, sv_m}, 32'd0);
    chk("mid.held.ready", {31'd0, lr_m}, 32'd0);
    reset = 1'b0;
    #1;
    chk_idle("mid.rel");
    // First accept on the first edge after release.
    D = 4'b0011; load_valid = 1'b1;
    tick();
`ifdef PIPO_TX_PARITY_EN
    chk_seq("post", 16'b00110, FL, 16'd0, -1, 4'd0, 1'b0);
`else
    chk_seq("post", 16'b0011, FL, 16'd0, -1, 4'd0, 1'b0);
`endif
    chk_idle("post.end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/piso_tx4.md
PISO_TX4 -- requirements
Module: piso_tx4

Interface
REQ-001 The block SHALL have parameter MSB_FIRST, default 1, meaning 1 = D[3] is sent first and 0 = D[0] is sent first.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port D, input, 4 bits: parallel word to serialize.
REQ-005 The block SHALL have port load_valid, input, 1 bit: D holds a word to send.
REQ-006 The block SHALL have port load_ready, output, 1 bit: the block can accept a word this cycle.
REQ-007 The block SHALL have port sout, output, 1 bit: serial data bit.
REQ-008 The block SHALL have port sout_valid, output, 1 bit: sout carries a frame bit this cycle.
REQ-009 The block SHALL have port frame_start, output, 1 bit: high with the first bit of each frame.
REQ-010 The block SHALL have port busy, output, 1 bit: a frame is in progress.

Function
REQ-011 The block SHALL have FSM states IDLE and SHIFT, plus PARITY when PARITY_EN is defined.
REQ-012 Accept SHALL occur on a rising edge where load_valid && load_ready; D SHALL be captured into a 4-bit shift register only on accept.
REQ-013 Accept in IDLE SHALL move the FSM to SHIFT with bit counter = 0.
REQ-014 First-bit timing SHALL be:
- sout_valid, frame_start and busy high for the first bit in the cycle after accept (latency 1).
- sout SHALL be the first bit (D[3] if MSB_FIRST, else D[0]).
REQ-015 In SHIFT, each edge SHALL advance the counter 0..3 and shift the register; sout SHALL be registered, not combinational from D.
REQ-016 frame_start SHALL be high only in the counter = 0 cycle of each frame.
REQ-017 load_ready SHALL be high in IDLE and in the final bit cycle of a frame, and low otherwise.
- Final bit cycle: counter = 3 without PARITY_EN, or the PARITY state with it.
REQ-018 Accept in the final bit cycle SHALL start the next frame on the next edge with no idle gap (back-to-back frames).
REQ-019 After the final bit, with no accept, the FSM SHALL return to IDLE with sout_valid = 0, busy = 0 and sout = 0.
REQ-020 load_valid while load_ready = 0 SHALL be ignored: no capture and no state change; D changes mid-frame SHALL NOT affect the frame in flight.
REQ-021 The counter SHALL be 2 bits, wrapping 3 -> 0 only on frame restart; no other arithmetic is permitted.

Reset
REQ-022 While reset = 1 the outputs SHALL be: sout = 0, sout_valid = 0, frame_start = 0, busy = 0 and load_ready = 0; the FSM SHALL be IDLE and counter and shift register SHALL be 0.
REQ-023 Reset mid-frame SHALL abort the frame immediately (asynchronously), with no partial bits after reset asserts.
REQ-024 After reset deasserts, load_ready SHALL be 1 from the next evaluation, and the first accept SHALL be allowed on the first rising edge with reset = 0.

Configuration
REQ-025 With macro PIPO_TX_PARITY_EN defined, a fifth bit SHALL follow bit 3 in state PARITY:
- The bit is even parity (XOR of the 4 captured bits), with sout_valid = 1.
- The frame is 5 cycles.
REQ-026 Without PIPO_TX_PARITY_EN, the PARITY state and logic SHALL be absent and the frame SHALL be 4 cycles.

Verification
REQ-027 The bench SHALL check single frames:
- Reset pulse, then D = 4'b0011 with load_valid for 1 cycle, MSB_FIRST = 1.
- Required: sout = 0,0,1,1 on 4 consecutive cycles, frame_start on the first, then busy = 0.
- With PIPO_TX_PARITY_EN: sout = 0,0,1,1,0.
REQ-028 The bench SHALL check bit order: MSB_FIRST = 0, D = 4'b1100 -> sout = 0,0,1,1.
REQ-029 The bench SHALL check back-to-back frames: load_valid held with D = 4'b0101, then D = 4'b1101 in the final bit cycle -> sout = 0,1,0,1,1,1,0,1 with no gap, and frame_start on bits 0 and 4.
REQ-030 The bench SHALL check ignore-while-busy: D = 4'b0100 accepted, then D = 4'b1111 with load_valid at counter = 1 -> the frame stays 0,1,0,0 and no second frame follows unless load_valid is held into the final bit cycle.
REQ-031 The bench SHALL check reset mid-frame: reset asserted 2 ns after the counter = 1 edge -> all outputs 0 within the same cycle, load_ready = 0 while reset is high, and IDLE with load_ready = 1 after release.
REQ-032 The bench SHALL check the idle hold: load_valid = 0 for 10 cycles after reset -> sout_valid = 0, busy = 0 and load_ready = 1 throughout.
